hs_pipe_slice_chain: RTL and testbench

Parametrised chain of valid/ready register slices. It carries WORD_WIDTH-bit words from an upstream producer to a downstream consumer through STAGES identical stages, with no loss, no duplication and no reordering. MODE selects which paths are registered in each stage: forward (valid/data), backward (ready), or both. The block breaks timing paths between handshake-connected modules and reports live occupancy.

---
 rtl/hs_pipe_slice_chain_pkg.sv | 22 ++
 rtl/hs_pipe_slice_chain_stage.sv | 116 +++++++++++
 rtl/hs_pipe_slice_chain.sv | 113 +++++++++++
 tb/tb_hs_pipe_slice_chain.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hs_pipe_slice_chain_pkg.sv
// hs_pipe_pkg: shared definitions for the handshake slice chain.
//   HS_MODE_*  : per-stage register modes (forward / backward / full skid)
//   hs_st_e    : occupancy state of a fully registered stage
//   hs_lvl_w() : width of the occupancy counter for a given stage count
package hs_pipe_pkg;

  localparam int HS_MODE_FWD  = 0;
  localparam int HS_MODE_BWD  = 1;
  localparam int HS_MODE_FULL = 2;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_HALF,
    ST_FULL
  } hs_st_e;

  // Counter must hold 0..2*stages (worst case is the 2-entry mode).
  function automatic int hs_lvl_w(input int stages);
    return $clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/hs_pipe_slice_chain_stage.sv
// hs_pipe_stage: one valid/ready register slice.
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid_i/in_data_i  : upstream word, in_ready_o back-pressure
//   out_valid_o/out_data_o: downstream word, out_ready_i back-pressure
// MODE selects the registered path: forward (v/d), backward (skid) or both.
module hs_pipe_stage
  import hs_pipe_pkg::*;
#(
  parameter int WORD_WIDTH = 8,
  parameter int MODE       = HS_MODE_FULL
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  input  logic [WORD_WIDTH-1:0] in_data_i,
  output logic                  in_ready_o,
  output logic                  out_valid_o,
  output logic [WORD_WIDTH-1:0] out_data_o,
  input  logic                  out_ready_i
);

  if (MODE == HS_MODE_FWD) begin : g_fwd
    logic                  v_q;
    logic [WORD_WIDTH-1:0] d_q;

    // Can refill in the same cycle the held word leaves.
    assign in_ready_o  = !v_q || out_ready_i;
    assign out_valid_o = v_q;
    assign out_data_o  = d_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        d_q <= '0;
      end else if (in_valid_i && in_ready_o) begin
        v_q <= 1'b1;
        d_q <= in_data_i;
      end else if (v_q && out_ready_i) begin
        v_q <= 1'b0;
      end
    end
  end else if (MODE == HS_MODE_BWD) begin : g_bwd
    logic                  skv_q;
    logic [WORD_WIDTH-1:0] skd_q;

    // Data passes straight through; the skid catches the word offered
    // in the cycle downstream stalls, so ready can be a flop.
    assign in_ready_o  = !skv_q;
    assign out_valid_o = in_valid_i || skv_q;
    assign out_data_o  = skv_q ? skd_q : in_data_i;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        skv_q <= 1'b0;
        skd_q <= '0;
      end else if (in_valid_i && !skv_q && !out_ready_i) begin
        skv_q <= 1'b1;
        skd_q <= in_data_i;
      end else if (out_valid_o && out_ready_i) begin
        skv_q <= 1'b0;
      end
    end
  end else if (MODE == HS_MODE_FULL) begin : g_full
    hs_st_e                state_q, state_d;
    logic [WORD_WIDTH-1:0] m_q, m_d, sk_q, sk_d;
    logic                  in_hs, out_hs;

    assign in_ready_o  = (state_q != ST_FULL);
    assign out_valid_o = (state_q != ST_EMPTY);
    assign out_data_o  = m_q;
    assign in_hs       = in_valid_i && in_ready_o;
    assign out_hs      = out_valid_o && out_ready_i;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q <= ST_EMPTY;
        m_q     <= '0;
        sk_q    <= '0;
      end else begin
        state_q <= state_d;
        m_q     <= m_d;
        sk_q    <= sk_d;
      end
    end

    always_comb begin
      state_d = state_q;
      m_d     = m_q;
      sk_d    = sk_q;
      case (state_q)
        ST_EMPTY: if (in_hs) begin
          state_d = ST_HALF;
          m_d     = in_data_i;
        end
        ST_HALF: begin
          if (in_hs && out_hs) begin
            m_d = in_data_i;
          end else if (in_hs) begin
            state_d = ST_FULL;
            sk_d    = in_data_i;
          end else if (out_hs) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: if (out_hs) begin
          state_d = ST_HALF;
          m_d     = sk_q;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end else begin : g_bad_mode
    $error("hs_pipe_stage: MODE must be 0, 1 or 2");
  end

endmodule

// File: rtl/hs_pipe_slice_chain.sv
// hs_pipe_slice_chain: STAGES valid/ready slices in series with occupancy.
//   clk, rst_n              : clock, synchronous active-low reset
//   up_valid/up_data        : producer side, up_ready back-pressure
//   down_valid/down_data    : consumer side, down_ready back-pressure
//   level                   : words currently held in the chain
//   stall_cnt (optional)    : saturating count of down_valid && !down_ready
// Build option: define HS_STALL_CNT_EN to add the stall_cnt port.
module hs_pipe_slice_chain
  import hs_pipe_pkg::*;
#(
  parameter  int WORD_WIDTH = 8,
  parameter  int STAGES     = 2,
  parameter  int MODE       = HS_MODE_FULL,
  localparam int LVL_W      = hs_lvl_w(STAGES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  up_valid,
  input  logic [WORD_WIDTH-1:0] up_data,
  output logic                  up_ready,
  output logic                  down_valid,
  output logic [WORD_WIDTH-1:0] down_data,
  input  logic                  down_ready,
  output logic [LVL_W-1:0]      level
`ifdef HS_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  logic             ready_en_q;
  logic             accept_en;
  logic [LVL_W-1:0] level_q;
  logic             up_hs, down_hs;

  // rst_n is folded in so the head is closed in every reset cycle, not
  // just from the edge after reset is first sampled.
  assign accept_en = ready_en_q & rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) ready_en_q <= 1'b0;
    else        ready_en_q <= 1'b1;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic                  in_v, in_r, out_v, out_r;
    logic [WORD_WIDTH-1:0] in_d, out_d;

    hs_pipe_stage #(
      .WORD_WIDTH (WORD_WIDTH),
      .MODE       (MODE)
    ) u_stage (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (in_v),
      .in_data_i   (in_d),
      .in_ready_o  (in_r),
      .out_valid_o (out_v),
      .out_data_o  (out_d),
      .out_ready_i (out_r)
    );

    if (k == 0) begin : g_head
      // Gate valid too: in pass-through mode an ungated word would reach
      // the output without being counted as accepted.
      assign in_v = up_valid & accept_en;
      assign in_d = up_data;
    end else begin : g_link
      assign in_v = g_st[k-1].out_v;
      assign in_d = g_st[k-1].out_d;
    end

    if (k == STAGES - 1) begin : g_tail
      assign out_r = down_ready;
    end else begin : g_mid
      assign out_r = g_st[k+1].in_r;
    end
  end

  assign up_ready   = g_st[0].in_r & accept_en;
  assign down_valid = g_st[STAGES-1].out_v;
  assign down_data  = g_st[STAGES-1].out_d;

  assign up_hs   = up_valid && up_ready;
  assign down_hs = down_valid && down_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_q <= '0;
    end else if (up_hs && !down_hs) begin
      level_q <= level_q + LVL_W'(1);
    end else if (down_hs && !up_hs) begin
      level_q <= level_q - LVL_W'(1);
    end
  end

  assign level = level_q;

`ifdef HS_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (down_valid && !down_ready && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_hs_pipe_slice_chain.sv
// Bench for hs_pipe_slice_chain: twelve instances (directed configs plus
// every MODE at STAGES 1/4/8) share one clock; a queue per instance holds
// the words that should be in flight and is checked every cycle.
module tb_hs_pipe_slice_chain;

  localparam int NI = 12;
  localparam int CM [NI] = '{2, 1, 0, 0, 0, 0, 1, 1, 1, 2, 2, 2};
  localparam int CS [NI] = '{2, 1, 3, 1, 4, 8, 1, 4, 8, 1, 4, 8};

  logic       clk = 1'b0;
  logic       rn [NI];
  logic       uv [NI];
  logic [7:0] ud [NI];
  logic       ur [NI];
  logic       dv [NI];
  logic [7:0] dd [NI];
  logic       dr [NI];
  logic [4:0] lv [NI];
`ifdef HS_STALL_CNT_EN
  logic [15:0] sc [NI];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int LW = $clog2(2 * CS[g] + 1);
    logic [LW-1:0] l;

    hs_pipe_slice_chain #(
      .WORD_WIDTH (8),
      .STAGES     (CS[g]),
      .MODE       (CM[g])
    ) u_dut (
      .clk        (clk),
      .rst_n      (rn[g]),
      .up_valid   (uv[g]),
      .up_data    (ud[g]),
      .up_ready   (ur[g]),
      .down_valid (dv[g]),
      .down_data  (dd[g]),
      .down_ready (dr[g]),
      .level      (l)
`ifdef HS_STALL_CNT_EN
      ,
      .stall_cnt  (sc[g])
`endif
    );

    assign lv[g] = 5'(l);
  end

  int         n_chk  = 0;
  int         n_fail = 0;
  logic [7:0] mq [NI][$];
  bit         stall_prev [NI];
  bit         rst_prev [NI];
  logic [7:0] hold_d [NI];

  task automatic chk(input int i, input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s inst%0d: got %0h expected %0h", tag, i, obs, exp);
    end
  endtask

  // Reference model: called #1 after inputs are driven; checks the cycle,
  // applies that cycle's handshakes, then advances to the next negedge.
  task automatic step();
    for (int i = 0; i < NI; i++) begin
      bit uhs, dhs;
      int cap;
      uhs = uv[i] && ur[i];
      dhs = dv[i] && dr[i];
      cap = (CM[i] == 2) ? 2 * CS[i] : CS[i];
      if (!rn[i] || rst_prev[i]) chk(i, "up_ready_gated", ur[i], 0);
      chk(i, "level", lv[i], mq[i].size());
      if (stall_prev[i]) begin
        chk(i, "hold_valid", dv[i], 1);
        chk(i, "hold_data", dd[i], hold_d[i]);
      end
      if (!rn[i]) begin
        mq[i].delete();
        stall_prev[i] = 0;
        rst_prev[i]   = 1;
        continue;
      end
      if (uhs) mq[i].push_back(ud[i]);
      if (dv[i]) chk(i, "valid_has_word", mq[i].size() != 0, 1);
      if (dhs && mq[i].size() != 0) chk(i, "data_order", dd[i], mq[i].pop_front());
      chk(i, "capacity", mq[i].size() <= cap, 1);
      stall_prev[i] = dv[i] && !dr[i];
      hold_d[i]     = dd[i];
      rst_prev[i]   = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    int acc, rec, w;
    bit dropped, held;
    for (int i = 0; i < NI; i++) begin
      rn[i] = 1'b0; uv[i] = 1'b0; ud[i] = '0; dr[i] = 1'b0;
      stall_prev[i] = 0; rst_prev[i] = 1;
    end
    @(posedge clk);
    @(negedge clk);
    #1 step();
    for (int i = 0; i < NI; i++) rn[i] = 1'b1;
    #1 step();
    #1 step();

    // 1: MODE2/2 streaming, 2-cycle latency, one word per cycle
    for (int c = 0; c < 18; c++) begin
      uv[0] = (c < 16); ud[0] = 8'(c + 1); dr[0] = 1'b1;
      #1;
      if (c < 16) chk(0, "t1_up_ready", ur[0], 1);
      if (c >= 2) begin
        chk(0, "t1_valid", dv[0], 1);
        chk(0, "t1_data", dd[0], c - 1);
      end
      if (c >= 2 && c < 16) chk(0, "t1_level", lv[0], 2);
      step();
    end

    // 2: MODE2/2 fills to 4 words, then drains in order
    dr[0] = 1'b0; acc = 0;
    for (int c = 0; c < 8; c++) begin
      uv[0] = 1'b1; ud[0] = 8'hA0 + 8'(acc);
      #1;
      if (ur[0]) acc++;
      step();
    end
    uv[0] = 1'b0;
    #1;
    chk(0, "t2_accepted", acc, 4);
    chk(0, "t2_full_ready", ur[0], 0);
    chk(0, "t2_full_level", lv[0], 4);
    step();
    for (int d = 0; d < 4; d++) begin
      dr[0] = 1'b1;
      #1;
      chk(0, "t2_drain_valid", dv[0], 1);
      chk(0, "t2_drain_data", dd[0], 8'hA0 + d);
      // freed slot travels back one registered stage per cycle
      if (d == 2) chk(0, "t2_ready_back", ur[0], 1);
      step();
    end

    // 3: MODE1/1 single-cycle stall on 0x13
    w = 0; rec = 0; dropped = 0; held = 0;
    for (int c = 0; c < 40 && rec < 16; c++) begin
      uv[1] = (w < 16); ud[1] = 8'h10 + 8'(w); dr[1] = 1'b1;
      #1;
      if (held) begin
        chk(1, "t3_hold_data", dd[1], 8'h13);
        chk(1, "t3_ready_low", ur[1], 0);
        held = 0;
      end else if (!dropped && dv[1] && dd[1] == 8'h13) begin
        dr[1] = 1'b0; dropped = 1; held = 1;
        #1;
      end
      if (uv[1] && ur[1]) w++;
      if (dv[1] && dr[1]) rec++;
      step();
    end
    chk(1, "t3_received", rec, 16);

    // 4: MODE0/3 reset while full
    dr[2] = 1'b0; uv[2] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      ud[2] = 8'h40 + 8'(c);
      #1 step();
    end
    #1;
    chk(2, "t4_full_ready", ur[2], 0);
    chk(2, "t4_full_level", lv[2], 3);
    step();
    rn[2] = 1'b0;
    #1;
    chk(2, "t4_rst_ready", ur[2], 0);
    step();
    rn[2] = 1'b1; dr[2] = 1'b1;
    #1;
    chk(2, "t4_post_valid", dv[2], 0);
    chk(2, "t4_post_level", lv[2], 0);
    chk(2, "t4_post_ready", ur[2], 0);
    step();
    rec = 0;
    for (int c = 0; c < 10; c++) begin
      ud[2] = 8'h60 + 8'(c);
      #1;
      if (c == 0) chk(2, "t4_ready_back", ur[2], 1);
      if (dv[2] && dr[2]) rec++;
      step();
    end
    chk(2, "t4_flow", rec, 7);
    uv[2] = 1'b0;

    // 5: random traffic on every instance
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NI; i++) begin
        if (c < 1000) begin
          uv[i] = ($urandom_range(0, 3) != 0);
          dr[i] = ($urandom_range(0, 1) != 0);
        end else begin
          uv[i] = ($urandom_range(0, 1) != 0);
          dr[i] = ($urandom_range(0, 3) != 0);
        end
        ud[i] = 8'($urandom);
      end
      #1 step();
    end

`ifdef HS_STALL_CNT_EN
    // 6: stall counter count and saturation
    uv[0] = 1'b0; dr[0] = 1'b0; rn[0] = 1'b0;
    #1 step();
    rn[0] = 1'b1;
    #1 step();
    uv[0] = 1'b1; ud[0] = 8'h55;
    #1 step();
    uv[0] = 1'b0;
    for (int c = 0; c < 10 && !dv[0]; c++) begin
      #1 step();
    end
    for (int c = 0; c < 5; c++) begin
      #1 step();
    end
    #1;
    chk(0, "t6_stall5", sc[0], 5);
    force g_dut[0].u_dut.stall_q = 16'hFFFE;
    #1;
    release g_dut[0].u_dut.stall_q;
    step();
    #1 step();
    #1 step();
    #1;
    chk(0, "t6_saturate", sc[0], 16'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
